multicycle_alu: RTL and testbench

- Parametrised, registered ALU for the next-generation CPU datapath.
- Single-cycle logic, arithmetic and compare ops: result in 1 cycle.
- Iterative shifts (1 bit/cycle) and unsigned shift-add multiply: multi-cycle.
- Start/Done handshake lets the control unit stall the pipeline while the block is busy.

---
 rtl/multicycle_alu.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// ----------------------------------------------------------------------------
// multicycle_alu
//   Registered ALU with a Start/Done handshake. Logic, add/sub and compare
//   ops finish in one cycle. Shifts move one bit per cycle. MUL is an
//   unsigned shift-add that takes WIDTH cycles. Result and flags are
//   written only when an operation completes, and they hold after that.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset (takes priority over start_i)
//   start_i      request, sampled only while ready_o=1
//   op_i         operation code
//   a_i, b_i     operands
//   shamt_i      shift amount for SLL/SRL/SRA
//   ready_o      block can accept start_i this cycle (IDLE or DONE)
//   busy_o       iterative op in progress (SHIFT or MUL)
//   done_o       one-cycle pulse: result_o and flags are valid
//   result_o     registered result
//   zero_o       result_o == 0
//   overflow_o   signed overflow (ADD/SUB); MUL: high product half nonzero
//   carry_out_o  ADD carry / SUB no-borrow; 0 for every other op
//   illegal_o    op_i was not a defined code
// ----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               zero_o,
    output logic               overflow_o,
    output logic               carry_out_o,
    output logic               illegal_o
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1100;

    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] MUL_LAST = SHAMT_W'(WIDTH - 1);
    localparam logic [WIDTH:0]     ONE_X    = (WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [3:0]           op_q;
    logic [SHAMT_W-1:0]   cnt_q;      // shifts: bits left; MUL: step index
    logic [WIDTH-1:0]     work_q;     // shift working register
    logic                 fill_q;     // bit shifted in on right shifts
    logic [2*WIDTH-1:0]   acc_q;      // MUL partial product
    logic [2*WIDTH-1:0]   mcand_q;    // multiplicand, moves left each step
    logic [WIDTH-1:0]     mplier_q;   // multiplier, moves right each step
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 ovf_q;
    logic                 cout_q;
    logic                 ill_q;

    // Results for one-cycle ops, computed from the live inputs. They are
    // stored only on the accepting edge, when the inputs and the latched
    // copies are the same.
    logic [WIDTH-1:0]     res_d;
    logic [WIDTH:0]       sum_d;
    logic                 ovf_d;
    logic                 cout_d;
    logic                 ill_d;
    logic [WIDTH-1:0]     shift_d;
    logic [2*WIDTH-1:0]   prod_d;

    always_comb begin
        res_d  = '0;
        sum_d  = '0;
        ovf_d  = 1'b0;
        cout_d = 1'b0;
        ill_d  = 1'b0;
        case (op_i)
            OP_AND:  res_d = a_i & b_i;
            OP_OR:   res_d = a_i | b_i;
            OP_XOR:  res_d = a_i ^ b_i;
            OP_NOR:  res_d = ~(a_i | b_i);
            OP_ADD: begin
                sum_d  = {1'b0, a_i} + {1'b0, b_i};
                res_d  = sum_d[MSB:0];
                cout_d = sum_d[WIDTH];
                ovf_d  = (a_i[MSB] == b_i[MSB]) && (sum_d[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                sum_d  = {1'b0, a_i} + {1'b0, ~b_i} + ONE_X;
                res_d  = sum_d[MSB:0];
                cout_d = sum_d[WIDTH];
                ovf_d  = (a_i[MSB] != b_i[MSB]) && (sum_d[MSB] != a_i[MSB]);
            end
            // A direct signed compare stays correct even when A - B overflows
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            // A zero-length shift finishes in one cycle with Result = A.
            // MUL always goes through the MUL state and never uses this value.
            OP_SLL, OP_SRL, OP_SRA, OP_MUL: res_d = a_i;
            default: ill_d = 1'b1;
        endcase
    end

    always_comb begin
        shift_d = (op_q == OP_SLL) ? {work_q[MSB-1:0], 1'b0}
                                   : {fill_q, work_q[MSB:1]};
        prod_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            fill_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        op_q <= op_i;
                        if (op_i == OP_MUL) begin
                            state_q  <= S_MUL;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, a_i};
                            mplier_q <= b_i;
                        end else if ((op_i == OP_SLL || op_i == OP_SRL ||
                                      op_i == OP_SRA) && shamt_i != '0) begin
                            state_q <= S_SHIFT;
                            cnt_q   <= shamt_i;
                            work_q  <= a_i;
                            fill_q  <= (op_i == OP_SRA) & a_i[MSB];
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= res_d;
                            zero_q   <= (res_d == '0);
                            ovf_q    <= ovf_d;
                            cout_q   <= cout_d;
                            ill_q    <= ill_d;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q  <= S_DONE;
                        result_q <= shift_d;
                        zero_q   <= (shift_d == '0);
                        ovf_q    <= 1'b0;
                        cout_q   <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q    <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == MUL_LAST) begin
                        state_q  <= S_DONE;
                        result_q <= prod_d[MSB:0];
                        zero_q   <= (prod_d[MSB:0] == '0);
                        ovf_q    <= |prod_d[2*WIDTH-1:WIDTH];
                        cout_q   <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_MUL);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;
    assign carry_out_o = cout_q;
    assign illegal_o   = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu (WIDTH=16). The expected result, flags and
// latency of each op come from a reference model written with integer
// arithmetic.
module tb_multicycle_alu;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic [SW-1:0] shamt;
    logic          ready, busy, done, zero, ovf, cout, ill;
    logic [W-1:0]  result;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .a_i(a), .b_i(b), .shamt_i(shamt),
        .ready_o(ready), .busy_o(busy), .done_o(done), .result_o(result),
        .zero_o(zero), .overflow_o(ovf), .carry_out_o(cout), .illegal_o(ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference model
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [SW-1:0] s, output logic [W-1:0] r, output logic z,
                         output logic v, output logic c, output logic il, output int lat);
        int sx, sy, ss;
        longint p;
        logic signed [W-1:0] xs;
        r = 0; v = 0; c = 0; il = 0; lat = 1;
        sx = int'($signed(x));
        sy = int'($signed(y));
        xs = x;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x ^ y;
            4'b0011: r = ~(x | y);
            4'b0100: begin
                r = W'(int'(x) + int'(y));
                c = (int'(x) + int'(y)) > 65535;
                ss = sx + sy;
                v = (ss > 32767) || (ss < -32768);
            end
            4'b1100: begin
                r = W'(int'(x) - int'(y));
                c = (x >= y);
                ss = sx - sy;
                v = (ss > 32767) || (ss < -32768);
            end
            4'b1001: r = (sx < sy) ? 1 : 0;
            4'b1010: r = (x < y) ? 1 : 0;
            4'b0101: begin r = x << s; lat = (s == 0) ? 1 : int'(s) + 1; end
            4'b0110: begin r = x >> s; lat = (s == 0) ? 1 : int'(s) + 1; end
            4'b0111: begin r = xs >>> s; lat = (s == 0) ? 1 : int'(s) + 1; end
            4'b1000: begin
                p = longint'(x) * longint'(y);
                r = W'(p);
                v = (p >> W) != 0;
                lat = W + 1;
            end
            default: il = 1;
        endcase
        z = (r == 0);
    endtask

    // Issues one op and waits for Done. With now=1 the call starts at the
    // negedge of a DONE cycle, so the op is issued back-to-back. With noisy=1
    // the inputs are scrambled after acceptance and Start is pulsed at random
    // while the block is busy.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [SW-1:0] s,
                          input bit now, input bit noisy);
        logic [W-1:0] er;
        logic ez, ev, ec, ei;
        int elat, lat, nbusy;
        model(o, x, y, s, er, ez, ev, ec, ei, elat);
        if (!now) @(negedge clk);
        chk({tag, ".ready"}, ready, 1'b1);
        op = o; a = x; b = y; shamt = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (noisy) begin
            a = W'($urandom); b = W'($urandom); op = 4'($urandom); shamt = SW'($urandom);
        end
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (noisy) start = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, ".lat"},  lat, elat);
        chk({tag, ".busy"}, nbusy, elat - 1);
        chk({tag, ".res"},  result, er);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".ovf"},  ovf, ev);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ill"},  ill, ei);
    endtask

    initial begin
        int dcnt;
        logic [3:0] ro;
        rst = 1'b1; start = 1'b0; op = 0; a = 0; b = 0; shamt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.ready", ready, 1'b1);
        chk("rst.busy",  busy, 1'b0);
        chk("rst.done",  done, 1'b0);
        chk("rst.res",   result, 0);
        chk("rst.flags", {zero, ovf, cout, ill}, 4'b0000);

        run_op("add",    4'b0100, 16'd100,  16'd85,   0, 0, 0);
        // Result and flags must hold in IDLE, with done dropped
        @(negedge clk);
        chk("hold.done", done, 1'b0);
        chk("hold.res",  result, 16'd185);
        run_op("sub0",   4'b1100, 16'd100,  16'd100,  0, 0, 0);
        run_op("addovf", 4'b0100, 16'h7FFF, 16'h0001, 0, 0, 0);
        run_op("addcry", 4'b0100, 16'hFFFF, 16'h0001, 0, 0, 0);
        run_op("sra4",   4'b0111, 16'h8F00, 16'h0000, 4, 0, 0);
        run_op("sll0",   4'b0101, 16'h1234, 16'h0000, 0, 0, 0);
        run_op("mul",    4'b1000, 16'd300,  16'd250,  0, 0, 1);
        run_op("slt",    4'b1001, 16'hFFFF, 16'h0001, 0, 0, 0);
        run_op("sltu",   4'b1010, 16'hFFFF, 16'h0001, 0, 0, 0);
        run_op("sltovf", 4'b1001, 16'h8000, 16'h7FFF, 0, 0, 0);
        run_op("ill",    4'b1111, 16'h5555, 16'hAAAA, 0, 0, 0);
        run_op("srl15",  4'b0110, 16'hFFFF, 16'h0000, 15, 0, 1);
        // Back-to-back: each op after the first is issued in the DONE cycle
        run_op("b2b0",   4'b0111, 16'h8001, 16'h0000, 3, 0, 0);
        run_op("b2b1",   4'b1000, 16'hFFFF, 16'hFFFF, 0, 1, 0);
        run_op("b2b2",   4'b0000, 16'hF0F0, 16'h3C3C, 0, 1, 0);

        // Reset during the 8th MUL cycle aborts the op
        @(negedge clk);
        op = 4'b1000; a = 16'd1234; b = 16'd4321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort.busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.ready",  ready, 1'b1);
        chk("abort.busy",   busy, 1'b0);
        chk("abort.res",    result, 0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("abort.nodone", dcnt, 0);

        // Random ops, including illegal codes and noisy inputs
        for (int i = 0; i < 120; i++) begin
            ro = 4'($urandom);
            run_op($sformatf("rnd%0d", i), ro, W'($urandom), W'($urandom),
                   SW'($urandom), ((i % 3) == 1 && done), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
